// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment check used when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // Reserved size is reported through the same error path as misalignment.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a memory word,
// and merges store data into the previously read word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rword_i[7:0];
    case (addr_lo_i)
      2'b01:   ld_byte = rword_i[15:8];
      2'b10:   ld_byte = rword_i[23:16];
      2'b11:   ld_byte = rword_i[31:24];
      default: ld_byte = rword_i[7:0];
    endcase
    ld_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SZ_BYTE: load_data_o = {{24{signed_i & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_data_o = {{16{signed_i & ld_half[15]}}, ld_half};
      default: load_data_o = rword_i;
    endcase
  end

  // Each byte lane either keeps the read-back byte or takes its slice of the store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       lane_en;
    logic [7:0] lane_src;

    always_comb begin
      lane_en  = 1'b0;
      lane_src = wdata_i[8*gi +: 8];
      case (size_i)
        SZ_BYTE: begin
          lane_en  = (addr_lo_i == LANE);
          lane_src = wdata_i[7:0];
        end
        SZ_HALF: begin
          lane_en  = (addr_lo_i[1] == LANE[1]);
          lane_src = LANE[0] ? wdata_i[15:8] : wdata_i[7:0];
        end
        SZ_WORD: lane_en = 1'b1;
        default: lane_en = 1'b0;
      endcase
    end

    assign store_word_o[8*gi +: 8] = lane_en ? lane_src : rword_i[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding request, Moore FSM driving the DataMemory
// word port, with read-modify-write for byte and half stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
);

  lsu_state_e        state_q, state_d;
  logic              write_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rword_q;
  logic [DATA_W-1:0] load_data, store_word;
  logic              accept, req_err;

  assign req_err = req_misaligned(req_size, req_addr[1:0]);
  assign accept  = req_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rword_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        signed_q <= req_signed;
        err_q    <= req_err;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      // DataMemory has updated ReadData on the preceding negedge.
      if (state_q == ST_READ) rword_q <= mem_ReadData;
    end
  end

  lsu_lane_align u_align (
    .size_i      (size_q),
    .signed_i    (signed_q),
    .addr_lo_i   (addr_q[1:0]),
    .rword_i     (rword_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .store_word_o(store_word)
  );

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_err      = 1'b0;
    mem_address   = '0;
    mem_MemRead   = 1'b0;
    mem_MemWrite  = 1'b0;
    mem_WriteData = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                              state_d = ST_RESP;
          else if (!req_write || req_size != SZ_WORD) state_d = ST_READ;
          else                                      state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        mem_MemRead = 1'b1;
        mem_address = {addr_q[ADDR_W-1:2], 2'b00};
        state_d     = write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_MemWrite  = 1'b1;
        mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_WriteData = store_word;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (!write_q && !err_q) ? load_data : '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: load_store_unit wired to a behavioural DataMemory
// (negedge read/write, word0=5, word1=6, word2=7).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [6:0]  mem_address;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData = '0;

  logic [31:0] dmem [0:31] = '{0: 32'd5, 1: 32'd6, 2: 32'd7, default: 32'd0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_MemRead)  mem_ReadData <= dmem[mem_address[6:2]];
    if (mem_MemWrite) dmem[mem_address[6:2]] <= mem_WriteData;
  end

  load_store_unit #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_MemRead  (mem_MemRead),
    .mem_MemWrite (mem_MemWrite),
    .mem_WriteData(mem_WriteData),
    .mem_ReadData (mem_ReadData)
  );

  // Issue one request from an IDLE negedge; report the response and the
  // number of negedges (after the accept edge) until resp_valid was seen.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [6:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nrd, output int nwr);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rd = 'x; er = 1'bx;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (mem_MemRead)  nrd++;
      if (mem_MemWrite) nwr++;
      if (resp_valid) begin
        rd = resp_rdata; er = resp_err;
        break;
      end
    end
    $display("txn w=%0b sz=%0d sg=%0b addr=0x%02h wdata=0x%08h -> rdata=0x%08h err=%0b lat=%0d rd=%0d wr=%0d",
             w, sz, sg, a, wd, rd, er, lat, nrd, nwr);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp got v=%0b e=%0b d=0x%08h want 0/0/0", resp_valid, resp_err, resp_rdata); end
    checks++; if (mem_MemRead !== 1'b0 || mem_MemWrite !== 1'b0 || mem_address !== 7'h0 || mem_WriteData !== 32'h0) begin
      errors++; $display("FAIL reset_mem got rd=%0b wr=%0b a=0x%02h wd=0x%08h want all 0",
                         mem_MemRead, mem_MemWrite, mem_address, mem_WriteData); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_load_word();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(1'b0, SZ_WORD, 1'b0, 7'h04, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (rd !== 32'h6 || er !== 1'b0) begin errors++; $display("FAIL ldw_data got 0x%08h err=%0b want 0x00000006 err=0", rd, er); end
    checks++; if (lat != 2) begin errors++; $display("FAIL ldw_latency got %0d want 2", lat); end
    checks++; if (nrd != 1 || nwr != 0) begin errors++; $display("FAIL ldw_strobes got rd=%0d wr=%0d want 1/0", nrd, nwr); end
  endtask

  task automatic test_reset_in_write();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 7'h00; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (mem_MemWrite !== 1'b1 || mem_WriteData !== 32'h12345678) begin
      errors++; $display("FAIL rstw_in_write got wr=%0b wd=0x%08h want 1/0x12345678", mem_MemWrite, mem_WriteData); end
    rst = 1'b1; #1;
    checks++; if (mem_MemWrite !== 1'b0 || mem_MemRead !== 1'b0 || mem_WriteData !== 32'h0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstw_outputs got wr=%0b rd=%0b wd=0x%08h rdy=%0b v=%0b want 0/0/0/1/0",
                         mem_MemWrite, mem_MemRead, mem_WriteData, req_ready, resp_valid); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (dmem[0] !== 32'h5) begin errors++; $display("FAIL rstw_word0 got 0x%08h want 0x00000005", dmem[0]); end
    do_req(1'b0, SZ_WORD, 1'b0, 7'h00, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (rd !== 32'h5 || er !== 1'b0 || lat != 2) begin
      errors++; $display("FAIL rstw_after got 0x%08h err=%0b lat=%0d want 0x00000005/0/2", rd, er, lat); end
  endtask

  task automatic test_store_byte();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(1'b1, SZ_BYTE, 1'b1, 7'h01, 32'h000000FF, rd, er, lat, nrd, nwr);
    checks++; if (rd !== 32'h0 || er !== 1'b0 || lat != 3 || nwr != 1) begin
      errors++; $display("FAIL stb_resp got 0x%08h err=%0b lat=%0d wr=%0d want 0/0/3/1", rd, er, lat, nwr); end
    do_req(1'b0, SZ_BYTE, 1'b1, 7'h01, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL ldb_signed got 0x%08h want 0xffffffff", rd); end
    do_req(1'b0, SZ_BYTE, 1'b0, 7'h01, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL ldb_unsigned got 0x%08h want 0x000000ff", rd); end
    do_req(1'b0, SZ_WORD, 1'b0, 7'h00, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (rd !== 32'h0000FF05) begin errors++; $display("FAIL stb_word0 got 0x%08h want 0x0000ff05", rd); end
  endtask

  task automatic test_store_half();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(1'b1, SZ_HALF, 1'b0, 7'h0A, 32'h1234ABCD, rd, er, lat, nrd, nwr);
    checks++; if (lat != 3 || nwr != 1 || nrd != 1 || er !== 1'b0) begin
      errors++; $display("FAIL sth_timing got lat=%0d wr=%0d rd=%0d err=%0b want 3/1/1/0", lat, nwr, nrd, er); end
    checks++; if (dmem[2] !== 32'hABCD0007) begin errors++; $display("FAIL sth_word2 got 0x%08h want 0xabcd0007", dmem[2]); end
    do_req(1'b0, SZ_HALF, 1'b1, 7'h0A, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (rd !== 32'hFFFFABCD) begin errors++; $display("FAIL ldh_signed got 0x%08h want 0xffffabcd", rd); end
    do_req(1'b0, SZ_HALF, 1'b0, 7'h0A, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (rd !== 32'h0000ABCD) begin errors++; $display("FAIL ldh_unsigned got 0x%08h want 0x0000abcd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, nrd, nwr;
    do_req(1'b0, SZ_WORD, 1'b0, 7'h06, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || nrd != 0 || nwr != 0) begin
      errors++; $display("FAIL err_misword got err=%0b d=0x%08h lat=%0d rd=%0d wr=%0d want 1/0/1/0/0", er, rd, lat, nrd, nwr); end
    do_req(1'b0, SZ_RSVD, 1'b0, 7'h00, 32'h0, rd, er, lat, nrd, nwr);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || nrd != 0 || nwr != 0) begin
      errors++; $display("FAIL err_size11 got err=%0b d=0x%08h lat=%0d rd=%0d wr=%0d want 1/0/1/0/0", er, rd, lat, nrd, nwr); end
    do_req(1'b1, SZ_HALF, 1'b0, 7'h05, 32'hFFFF, rd, er, lat, nrd, nwr);
    checks++; if (er !== 1'b1 || lat != 1 || nwr != 0 || dmem[1] !== 32'h6) begin
      errors++; $display("FAIL err_mishalf got err=%0b lat=%0d wr=%0d word1=0x%08h want 1/1/0/0x00000006", er, lat, nwr, dmem[1]); end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  addrs [3] = '{7'h08, 7'h04, 7'h00};
    logic [31:0] exp_d [3] = '{32'hABCD0007, 32'h00000006, 32'h0000FF05};
    int acc = 0, pulses = 0, last = 0, gap_bad = 0, overlap = 0;
    logic rdy;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = addrs[0];
    for (int c = 0; c < 40 && pulses < 3; c++) begin
      if (resp_valid) begin
        $display("b2b resp %0d rdata=0x%08h", pulses, resp_rdata);
        checks++; if (resp_rdata !== exp_d[pulses]) begin
          errors++; $display("FAIL b2b_data%0d got 0x%08h want 0x%08h", pulses, resp_rdata, exp_d[pulses]); end
        if (req_ready) overlap++;
        pulses++;
      end
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy && req_valid) begin
        acc++;
        if (acc > 1 && (c - last) != 3) gap_bad++;
        last = c;
        if (acc < 3) req_addr = addrs[acc];
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++; if (acc != 3 || pulses != 3) begin errors++; $display("FAIL b2b_count got acc=%0d resp=%0d want 3/3", acc, pulses); end
    checks++; if (gap_bad != 0 || overlap != 0) begin
      errors++; $display("FAIL b2b_spacing got bad_gaps=%0d ready_in_resp=%0d want 0/0", gap_bad, overlap); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_reset_in_write();
    test_store_byte();
    test_store_half();
    test_errors();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
